flow_ctrl_multi: RTL and testbench

FLOW_CTRL_MULTI -- requirements
Module: flow_ctrl_multi

---
 rtl/flow_ctrl_multi_pkg.sv | 32 +++
 rtl/flow_ctrl_ch.sv | 88 ++++++++
 rtl/flow_ctrl_multi.sv | 101 ++++++++++
 tb/tb_flow_ctrl_multi.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/flow_ctrl_multi_pkg.sv
// flow_ctrl_multi_pkg: shared definitions for the multi-channel FIFO flow controller.
//   ch_state_e      one-hot per-channel FSM state encoding (6 bits)
//   ERR_CNT_W/MAX   width and saturation value of the error-entry counter
//   occ_* helpers   occupancy threshold checks used by every channel
package flow_ctrl_multi_pkg;

  typedef enum logic [5:0] {
    ST_INIT    = 6'b000001,
    ST_IDLE    = 6'b000010,
    ST_ACTIVE  = 6'b000100,
    ST_PAUSE   = 6'b001000,
    ST_ERROR   = 6'b010000,
    ST_RECOVER = 6'b100000
  } ch_state_e;

  localparam int unsigned ERR_CNT_W   = 8;
  localparam logic [7:0]  ERR_CNT_MAX = 8'hFF;

  // Anything at or beyond DEPTH counts as full (overflowed counters included).
  function automatic logic occ_full(input int unsigned occ, input int unsigned depth);
    return occ >= depth;
  endfunction

  function automatic logic occ_almost_full(input int unsigned occ, input int unsigned af_th);
    return occ >= af_th;
  endfunction

  function automatic logic occ_almost_empty(input int unsigned occ, input int unsigned ae_th);
    return occ <= ae_th;
  endfunction

endpackage

// File: rtl/flow_ctrl_ch.sv
// flow_ctrl_ch: supervisor FSM for one FIFO channel (INIT/IDLE/ACTIVE/PAUSE/ERROR/RECOVER).
//   clk, reset        clock, synchronous active-high reset
//   i_iniciar         start request (level)
//   i_en              channel enable; low forces INIT
//   i_clear_error     leaves ERROR towards RECOVER
//   i_occ             FIFO word count
//   o_continuar/o_pausa/o_error_full/o_idle  registered Moore outputs
//   o_stall           registered: channel is in PAUSE, ERROR or RECOVER
//   o_enter_err_c     combinational: channel enters ERROR at the next edge
module flow_ctrl_ch
  import flow_ctrl_multi_pkg::*;
#(
  parameter int unsigned CNT_W = 5,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AF_TH = 12,
  parameter int unsigned AE_TH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_iniciar,
  input  logic             i_en,
  input  logic             i_clear_error,
  input  logic [CNT_W-1:0] i_occ,
  output logic             o_continuar,
  output logic             o_pausa,
  output logic             o_error_full,
  output logic             o_idle,
  output logic             o_stall,
  output logic             o_enter_err_c
);

  ch_state_e r_state;
  ch_state_e w_next;
  logic      w_full;
  logic      w_af;
  logic      w_ae;
  logic      w_empty;

  assign w_full  = occ_full(32'(i_occ), DEPTH);
  assign w_af    = occ_almost_full(32'(i_occ), AF_TH);
  assign w_ae    = occ_almost_empty(32'(i_occ), AE_TH);
  assign w_empty = (i_occ == '0);

  // Next-state rules; disable outranks everything except reset.
  always_comb begin
    w_next = r_state;
    if (!i_en) begin
      w_next = ST_INIT;
    end else begin
      unique case (r_state)
        ST_INIT:    w_next = i_iniciar ? ST_IDLE : ST_INIT;
        ST_IDLE:    w_next = w_full ? ST_ERROR : (!w_empty ? ST_ACTIVE : ST_IDLE);
        ST_ACTIVE: begin
          if (w_full)       w_next = ST_ERROR;
          else if (w_af)    w_next = ST_PAUSE;
          else if (w_empty) w_next = ST_IDLE;
          else              w_next = ST_ACTIVE;
        end
        ST_PAUSE:   w_next = w_full ? ST_ERROR : (w_ae ? ST_ACTIVE : ST_PAUSE);
        ST_ERROR:   w_next = i_clear_error ? ST_RECOVER : ST_ERROR;
        ST_RECOVER: w_next = ST_IDLE;
        default:    w_next = ST_INIT;
      endcase
    end
  end

  assign o_enter_err_c = (w_next == ST_ERROR) && (r_state != ST_ERROR);

  // State and outputs registered together so outputs track the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_INIT;
      o_continuar  <= 1'b0;
      o_pausa      <= 1'b0;
      o_error_full <= 1'b0;
      o_idle       <= 1'b0;
      o_stall      <= 1'b0;
    end else begin
      r_state      <= w_next;
      o_continuar  <= (w_next == ST_ACTIVE);
      o_pausa      <= (w_next == ST_PAUSE) || (w_next == ST_RECOVER);
      o_error_full <= (w_next == ST_ERROR);
      o_idle       <= (w_next == ST_IDLE);
      o_stall      <= (w_next == ST_PAUSE) || (w_next == ST_ERROR) || (w_next == ST_RECOVER);
    end
  end

endmodule

// File: rtl/flow_ctrl_multi.sv
// flow_ctrl_multi: NUM_CH independent FIFO flow supervisors plus global status.
//   clk, reset      clock, synchronous active-high reset
//   iniciar         start request, ch_en per-channel enable, clear_error error acknowledge
//   occupancy       packed per-channel word counts, channel i at [i*CNT_W +: CNT_W]
//   continuar/pausa/error_full/idle  per-channel flow status
//   any_error       OR of error_full; all_idle AND of idle over enabled channels
//   err_cnt         saturating count of ERROR entries
module flow_ctrl_multi
  import flow_ctrl_multi_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CNT_W     = 5,
  parameter int unsigned AF_TH     = 12,
  parameter int unsigned AE_TH     = 4,
  parameter int unsigned PAUSE_ALL = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    iniciar,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    clear_error,
  input  logic [NUM_CH*CNT_W-1:0] occupancy,
  output logic [NUM_CH-1:0]       continuar,
  output logic [NUM_CH-1:0]       pausa,
  output logic [NUM_CH-1:0]       error_full,
  output logic [NUM_CH-1:0]       idle,
  output logic                    any_error,
  output logic                    all_idle,
  output logic [ERR_CNT_W-1:0]    err_cnt
);

  localparam int unsigned SUM_W = 16;

  logic [NUM_CH-1:0]    w_cont;
  logic [NUM_CH-1:0]    w_paus;
  logic [NUM_CH-1:0]    w_err;
  logic [NUM_CH-1:0]    w_idle;
  logic [NUM_CH-1:0]    w_stall;
  logic [NUM_CH-1:0]    w_enter;
  logic [NUM_CH-1:0]    w_live;
  logic                 w_glob;
  logic [SUM_W-1:0]     w_n_enter;
  logic [SUM_W-1:0]     w_sum;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    flow_ctrl_ch #(
      .CNT_W (CNT_W),
      .DEPTH (DEPTH),
      .AF_TH (AF_TH),
      .AE_TH (AE_TH)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .i_iniciar     (iniciar),
      .i_en          (ch_en[g]),
      .i_clear_error (clear_error),
      .i_occ         (occupancy[g*CNT_W +: CNT_W]),
      .o_continuar   (w_cont[g]),
      .o_pausa       (w_paus[g]),
      .o_error_full  (w_err[g]),
      .o_idle        (w_idle[g]),
      .o_stall       (w_stall[g]),
      .o_enter_err_c (w_enter[g])
    );
  end

  // Number of channels entering ERROR at the coming edge.
  always_comb begin
    w_n_enter = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_n_enter = w_n_enter + SUM_W'(w_enter[i]);
    end
  end

  assign w_sum = SUM_W'(r_err_cnt) + w_n_enter;

  // Saturating error-entry counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (w_sum > SUM_W'(ERR_CNT_MAX)) begin
      r_err_cnt <= ERR_CNT_MAX;
    end else begin
      r_err_cnt <= w_sum[ERR_CNT_W-1:0];
    end
  end

  // Global pause: channels still in INIT keep all outputs low.
  assign w_live     = w_cont | w_paus | w_err | w_idle;
  assign w_glob     = (PAUSE_ALL != 0) && (|(w_stall & ch_en));
  assign pausa      = w_paus | (w_live & {NUM_CH{w_glob}});
  assign continuar  = w_cont & ~{NUM_CH{w_glob}};
  assign error_full = w_err;
  assign idle       = w_idle;
  assign any_error  = |w_err;
  assign all_idle   = &(w_idle | ~ch_en);
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_flow_ctrl_multi.sv
// Bench for flow_ctrl_multi: two instances (PAUSE_ALL=0 and 1) share stimulus;
// every cycle both are compared with a behavioural model of the channel rules.
module tb_flow_ctrl_multi;

  localparam int NCH   = 4;
  localparam int CW    = 5;
  localparam int DEP   = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  localparam int S_INIT  = 0;
  localparam int S_IDLE  = 1;
  localparam int S_ACT   = 2;
  localparam int S_PAUSE = 3;
  localparam int S_ERR   = 4;
  localparam int S_REC   = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            iniciar;
  logic            clear_error;
  logic [NCH-1:0]  ch_en;
  logic [NCH*CW-1:0] occupancy;

  logic [NCH-1:0]  a_cont, a_paus, a_err, a_idle;
  logic            a_any, a_all;
  logic [7:0]      a_cnt;
  logic [NCH-1:0]  b_cont, b_paus, b_err, b_idle;
  logic            b_any, b_all;
  logic [7:0]      b_cnt;

  int m_st [NCH];
  int m_cnt;
  int checks;
  int errors;

  always #5 clk = ~clk;

  flow_ctrl_multi #(.NUM_CH(NCH), .DEPTH(DEP), .CNT_W(CW), .AF_TH(AF), .AE_TH(AE), .PAUSE_ALL(0)) dut (
    .clk(clk), .reset(reset), .iniciar(iniciar), .ch_en(ch_en), .clear_error(clear_error),
    .occupancy(occupancy), .continuar(a_cont), .pausa(a_paus), .error_full(a_err), .idle(a_idle),
    .any_error(a_any), .all_idle(a_all), .err_cnt(a_cnt));

  flow_ctrl_multi #(.NUM_CH(NCH), .DEPTH(DEP), .CNT_W(CW), .AF_TH(AF), .AE_TH(AE), .PAUSE_ALL(1)) dut_pa (
    .clk(clk), .reset(reset), .iniciar(iniciar), .ch_en(ch_en), .clear_error(clear_error),
    .occupancy(occupancy), .continuar(b_cont), .pausa(b_paus), .error_full(b_err), .idle(b_idle),
    .any_error(b_any), .all_idle(b_all), .err_cnt(b_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int occ_of(input int ch);
    logic [CW-1:0] v;
    v = occupancy[ch*CW +: CW];
    return int'(v);
  endfunction

  // Channel rules written directly from the requirement list.
  function automatic int rule_next(input int s, input bit en, input bit ini, input bit clr, input int occ);
    bit full;
    full = (occ >= DEP);
    if (!en) return S_INIT;
    case (s)
      S_INIT:  return ini ? S_IDLE : S_INIT;
      S_IDLE:  return full ? S_ERR : (occ > 0 ? S_ACT : S_IDLE);
      S_ACT:   return full ? S_ERR : (occ >= AF ? S_PAUSE : (occ == 0 ? S_IDLE : S_ACT));
      S_PAUSE: return full ? S_ERR : (occ <= AE ? S_ACT : S_PAUSE);
      S_ERR:   return clr ? S_REC : S_ERR;
      default: return S_IDLE;
    endcase
  endfunction

  task automatic model_edge();
    int entered;
    int ns;
    entered = 0;
    if (reset) begin
      for (int i = 0; i < NCH; i++) m_st[i] = S_INIT;
      m_cnt = 0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        ns = rule_next(m_st[i], ch_en[i], iniciar, clear_error, occ_of(i));
        if (ns == S_ERR && m_st[i] != S_ERR) entered++;
        m_st[i] = ns;
      end
      m_cnt = (m_cnt + entered > 255) ? 255 : m_cnt + entered;
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0] e_cont, e_paus, e_err, e_idle, p_cont, p_paus;
    logic e_all, glob;
    e_all = 1'b1;
    glob  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      e_cont[i] = (m_st[i] == S_ACT);
      e_paus[i] = (m_st[i] == S_PAUSE) || (m_st[i] == S_REC);
      e_err[i]  = (m_st[i] == S_ERR);
      e_idle[i] = (m_st[i] == S_IDLE);
      if (ch_en[i] && m_st[i] != S_IDLE) e_all = 1'b0;
      if (ch_en[i] && (m_st[i] == S_PAUSE || m_st[i] == S_ERR || m_st[i] == S_REC)) glob = 1'b1;
    end
    for (int i = 0; i < NCH; i++) begin
      p_paus[i] = e_paus[i] | (glob && m_st[i] != S_INIT);
      p_cont[i] = e_cont[i] & ~glob;
    end
    chk("continuar",    32'(a_cont), 32'(e_cont));
    chk("pausa",        32'(a_paus), 32'(e_paus));
    chk("error_full",   32'(a_err),  32'(e_err));
    chk("idle",         32'(a_idle), 32'(e_idle));
    chk("any_error",    32'(a_any),  32'(|e_err));
    chk("all_idle",     32'(a_all),  32'(e_all));
    chk("err_cnt",      32'(a_cnt),  32'(m_cnt));
    chk("pa_continuar", 32'(b_cont), 32'(p_cont));
    chk("pa_pausa",     32'(b_paus), 32'(p_paus));
    chk("pa_error_full",32'(b_err),  32'(e_err));
    chk("pa_idle",      32'(b_idle), 32'(e_idle));
    chk("pa_all_idle",  32'(b_all),  32'(e_all));
    chk("pa_err_cnt",   32'(b_cnt),  32'(m_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_occ(input int ch, input int v);
    occupancy[ch*CW +: CW] = CW'(v);
  endtask

  task automatic set_all_occ(input int v);
    for (int i = 0; i < NCH; i++) set_occ(i, v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_cnt  = 0;
    for (int i = 0; i < NCH; i++) m_st[i] = S_INIT;
    reset = 1'b1; iniciar = 1'b0; clear_error = 1'b0; ch_en = '0; occupancy = '0;
    step(); step();
    chk("rst_outputs", 32'({a_cont, a_paus, a_err, a_idle}), 32'h0);
    chk("rst_cnt", 32'(a_cnt), 32'h0);

    // Start all channels.
    reset = 1'b0; iniciar = 1'b1; ch_en = 4'hF;
    step();
    chk("start_idle", 32'(a_idle), 32'hF);
    chk("start_all_idle", 32'(a_all), 32'h1);

    // Ch0 hysteresis walk.
    set_occ(0, 5);  step(); chk("ch0_active", 32'(a_cont), 32'h1);
    set_occ(0, 12); step(); chk("ch0_pause",  32'(a_paus), 32'h1);
    set_occ(0, 8);  step(); chk("ch0_hold",   32'(a_paus), 32'h1);
    set_occ(0, 4);  step(); chk("ch0_resume", 32'(a_cont), 32'h1);

    // Ch1 overflow, hold, clear, recover.
    set_occ(1, 5);  step();
    set_occ(1, 16); step();
    chk("ch1_err", 32'(a_err), 32'h2);
    chk("ch1_cnt", 32'(a_cnt), 32'h1);
    for (int k = 0; k < 10; k++) step();
    chk("ch1_err_hold", 32'(a_err), 32'h2);
    set_occ(1, 0); clear_error = 1'b1; step();
    chk("ch1_recover", 32'(a_paus), 32'h2);
    clear_error = 1'b0; step();
    chk("ch1_idle", 32'(a_idle[1]), 32'h1);

    // Simultaneous entries, then saturate the counter.
    set_occ(0, 16); set_occ(2, 16); step();
    chk("dual_entry_cnt", 32'(a_cnt), 32'h3);
    set_all_occ(16); clear_error = 1'b1;
    for (int k = 0; k < 240; k++) step();
    chk("cnt_saturated", 32'(a_cnt), 32'hFF);
    set_all_occ(0);
    step(); step();
    clear_error = 1'b0; step();
    chk("post_sat_idle", 32'(a_idle), 32'hF);

    // Reset over ERROR with err_cnt=7.
    reset = 1'b1; step(); reset = 1'b0; step();
    set_all_occ(16); set_occ(3, 0); step();
    clear_error = 1'b1; step(); step(); step();
    set_occ(0, 0); set_occ(2, 0); step(); step(); step();
    clear_error = 1'b0; step();
    chk("pre_rst_cnt", 32'(a_cnt), 32'h7);
    chk("pre_rst_err", 32'(a_err), 32'h2);
    reset = 1'b1; set_all_occ(0); step();
    chk("rst_over_err", 32'({a_cont, a_paus, a_err, a_idle, 3'b000, a_any}), 32'h0);
    chk("rst_over_cnt", 32'(a_cnt), 32'h0);
    reset = 1'b0; step();

    // Disable ch2 while ACTIVE.
    set_occ(2, 5); step();
    ch_en = 4'b1011; step();
    chk("dis_all_idle", 32'(a_all), 32'h1);
    chk("dis_cont", 32'(a_cont), 32'h0);

    // Global pause behaviour.
    ch_en = 4'hF; step();
    set_all_occ(6); set_occ(3, 12); step(); step();
    chk("pa_pausa_all", 32'(b_paus), 32'hF);
    chk("pa_cont_none", 32'(b_cont), 32'h0);
    chk("npa_cont",     32'(a_cont), 32'h7);
    set_occ(3, 3); step();
    chk("pa_cont_back", 32'(b_cont), 32'hF);

    // Occupancy above DEPTH counts as full.
    set_occ(0, 20); step();
    chk("over_depth_err", 32'(a_err[0]), 32'h1);

    // Randomized phase.
    for (int k = 0; k < 600; k++) begin
      reset       = ($urandom_range(0, 63) == 0);
      iniciar     = ($urandom_range(0, 3) != 0);
      clear_error = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NCH; i++) begin
        ch_en[i] = ($urandom_range(0, 15) != 0);
        set_occ(i, int'($urandom_range(0, 20)));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
